// File: rtl/fpu_pkg.sv
// Shared FPU constants and the normalization result record.
package fpu_pkg;

  localparam int FPU_MANT_W   = 106;
  localparam int FPU_MANT_LOG = 7;
  localparam int FPU_NREQ     = 2;
  localparam int FPU_SRC_W    = $clog2(FPU_NREQ);
  localparam int FPU_TAG_W    = 4;

  typedef struct packed {
    logic [FPU_MANT_W-1:0]   value;
    logic [FPU_MANT_LOG:0]   shift;
    logic                    zero;
    logic [FPU_SRC_W-1:0]    src;
    logic [FPU_TAG_W-1:0]    tag;
  } norm_result_t;

endpackage

// File: rtl/fpu_pri_encoder.sv
// Leading-one detector: index of the most significant set bit.
// msb[WIDTH_LOG] flags an all-zero input; the index field is 0 in that case.
module fpu_pri_encoder import fpu_pkg::*; #(
  parameter int WIDTH     = FPU_MANT_W,
  parameter int WIDTH_LOG = FPU_MANT_LOG
) (
  input  logic [WIDTH-1:0]   value,
  output logic [WIDTH_LOG:0] msb
);

  // Scan upward so the highest set bit wins; bits above WIDTH read as zero.
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) msb[WIDTH_LOG-1:0] = i[WIDTH_LOG-1:0];
    end
    msb[WIDTH_LOG] = ~|value;
  end

endmodule

// File: rtl/fpu_norm_arbiter.sv
// Shared leading-one normalizer: round-robin arbiter feeding a 2-stage
// valid/ready pipeline (S1 = capture + encode, S2 = shifted result).
module fpu_norm_arbiter import fpu_pkg::*; #(
  parameter int WIDTH     = FPU_MANT_W,
  parameter int WIDTH_LOG = FPU_MANT_LOG,
  parameter int NREQ      = 2,
  parameter int TAG_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_value,
  input  logic [NREQ*TAG_W-1:0]     req_tag,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH-1:0]          res_value,
  output logic [WIDTH_LOG:0]        res_shift,
  output logic                      res_zero,
  output logic [$clog2(NREQ)-1:0]   res_src,
  output logic [TAG_W-1:0]          res_tag
);

  localparam int SRC_W = $clog2(NREQ);
  localparam logic [WIDTH_LOG:0] MAX_SHIFT = (WIDTH_LOG+1)'(WIDTH-1);

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               run;
  logic               s1_load, s2_load, accept;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_value;
  logic [SRC_W-1:0]   s1_src;
  logic [TAG_W-1:0]   s1_tag;
  logic [WIDTH_LOG:0] s1_msb_full;
  logic               s1_zero;
  logic [WIDTH_LOG:0] s1_shift;
  logic [WIDTH-1:0]   s1_norm;
  logic               unused_msb_flag;

  assign s2_load = ~res_valid | res_ready;
  // run keeps requesters off until the first clock after reset release,
  // so req_ready stays low while rst_n is asserted.
  assign s1_load = run & (~s1_valid | s2_load);
  assign accept  = grant_any & s1_load;

  // Round-robin search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // One-hot ready for the granted requester when S1 can take it.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Pointer advances past the winner only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) rr_ptr <= (grant_idx == SRC_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // S1 capture of the granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_src   <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_value <= req_value[int'(grant_idx)*WIDTH +: WIDTH];
        s1_src   <= grant_idx;
        s1_tag   <= req_tag[int'(grant_idx)*TAG_W +: TAG_W];
      end
    end
  end

  fpu_pri_encoder #(
    .WIDTH     (WIDTH),
    .WIDTH_LOG (WIDTH_LOG)
  ) u_enc (
    .value (s1_value),
    .msb   (s1_msb_full)
  );

  // Zero is detected locally; the encoder's own zero flag is not needed.
  assign unused_msb_flag = s1_msb_full[WIDTH_LOG];
  assign s1_zero  = ~|s1_value;
  assign s1_shift = s1_zero ? '0 : MAX_SHIFT - {1'b0, s1_msb_full[WIDTH_LOG-1:0]};
  assign s1_norm  = s1_value << s1_shift;

  // S2 result registers drive the res_* outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_value <= '0;
      res_shift <= '0;
      res_zero  <= 1'b0;
      res_src   <= '0;
      res_tag   <= '0;
    end else if (s2_load) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_value <= s1_norm;
        res_shift <= s1_shift;
        res_zero  <= s1_zero;
        res_src   <= s1_src;
        res_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// Bench for fpu_norm_arbiter: scoreboard monitor plus scenario tasks.
module tb_fpu_norm_arbiter;
  import fpu_pkg::*;

  localparam int W  = 106;
  localparam int WL = 7;
  localparam int N  = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*W-1:0]  req_value;
  logic [N*TW-1:0] req_tag;
  logic            res_valid, res_ready;
  logic [W-1:0]    res_value;
  logic [WL:0]     res_shift;
  logic            res_zero;
  logic [0:0]      res_src;
  logic [TW-1:0]   res_tag;

  int checks   = 0;
  int failures = 0;
  norm_result_t sb[$];
  int mptr = 0;
  logic [W-1:0] one = 1;

  fpu_norm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_shift(res_shift), .res_zero(res_zero),
    .res_src(res_src), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  function automatic norm_result_t model(input logic [W-1:0] v, input int src, input logic [TW-1:0] tag);
    norm_result_t r;
    int p;
    logic found;
    r = '0;
    r.src = FPU_SRC_W'(src);
    r.tag = tag;
    if (v == '0) begin
      r.zero = 1'b1;
    end else begin
      p = 0;
      found = 1'b0;
      for (int b = W - 1; b >= 0; b--) begin
        if (!found && v[b]) begin
          p = b;
          found = 1'b1;
        end
      end
      r.shift = (WL+1)'(W - 1 - p);
      r.value = v << (W - 1 - p);
    end
    return r;
  endfunction

  // Scoreboard: push on accept (checking the round-robin grant), pop on result.
  always @(negedge clk) begin : mon
    int eg;
    logic any;
    int idx;
    logic [N-1:0] exp_rdy;
    norm_result_t exp_r, got_r;
    if (!rst_n) begin
      sb.delete();
      mptr = 0;
    end else begin
      eg = 0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (!any && req_valid[idx]) begin
          any = 1'b1;
          eg = idx;
        end
      end
      if (req_ready != '0) begin
        exp_rdy = '0;
        if (any) exp_rdy[eg] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
          failures++;
          $display("FAIL grant: req_ready=%b expected=%b (req_valid=%b)", req_ready, exp_rdy, req_valid);
        end else begin
          sb.push_back(model(req_value[eg*W +: W], eg, req_tag[eg*TW +: TW]));
          mptr = (eg + 1) % N;
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected: tag=%0d src=%0d with empty scoreboard", res_tag, res_src);
        end else begin
          exp_r = sb.pop_front();
          got_r.value = res_value;
          got_r.shift = res_shift;
          got_r.zero  = res_zero;
          got_r.src   = res_src;
          got_r.tag   = res_tag;
          if (got_r !== exp_r) begin
            failures++;
            $display("FAIL result: got v=%h sh=%0d z=%0d src=%0d tag=%0d, expected v=%h sh=%0d z=%0d src=%0d tag=%0d",
                     got_r.value, got_r.shift, got_r.zero, got_r.src, got_r.tag,
                     exp_r.value, exp_r.shift, exp_r.zero, exp_r.src, exp_r.tag);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    res_ready = 1'b1;
    #3;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++;
    if ({res_value, res_shift, res_zero, res_src, res_tag} !== '0) begin
      failures++;
      $display("FAIL reset_res_data: v=%h sh=%0d z=%b src=%0d tag=%0d expected all 0", res_value, res_shift, res_zero, res_src, res_tag);
    end
    checks++;
    if (dut.rr_ptr !== '0) begin failures++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready_held: got %b expected 00", req_ready); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_normalize(input logic [W-1:0] v, input logic [TW-1:0] tag,
                                input logic [W-1:0] ev, input int es, input logic ez);
    req_value[W-1:0] = v;
    req_tag[TW-1:0]  = tag;
    req_valid = 2'b01;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL norm_accept: req_ready=%b expected 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL norm_latency_early: res_valid=%b expected 0", res_valid); end
    cyc();
    checks++;
    if (res_valid !== 1'b1 || res_value !== ev || res_shift !== (WL+1)'(es) ||
        res_zero !== ez || res_src !== 1'b0 || res_tag !== tag) begin
      failures++;
      $display("FAIL norm_result: vld=%b v=%h sh=%0d z=%b src=%0d tag=%0d expected vld=1 v=%h sh=%0d z=%b src=0 tag=%0d",
               res_valid, res_value, res_shift, res_zero, res_src, res_tag, ev, es, ez, tag);
    end
    cyc();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    res_ready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        req_value[i*W +: W] = W'({$urandom(), $urandom(), $urandom(), $urandom()}) >> $urandom_range(0, 100);
        req_tag[i*TW +: TW] = TW'($urandom());
      end
      exp = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (req_ready !== exp) begin failures++; $display("FAIL fair_alt c=%0d: req_ready=%b expected %b", c, req_ready, exp); end
      cyc();
    end
    req_valid = 2'b10;
    for (int c = 0; c < 4; c++) begin
      req_value[W +: W] = W'({$urandom(), $urandom(), $urandom(), $urandom()});
      req_tag[TW +: TW] = TW'(c);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin failures++; $display("FAIL fair_single c=%0d: req_ready=%b expected 10", c, req_ready); end
      cyc();
    end
    req_valid = 2'b00;
    cyc(); cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL fair_drain: %0d results outstanding expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int tag, accepts, c_tags[$], c_idx[$];
    logic acc, have_snap;
    logic [W+WL+1+1+1+TW-1:0] snap;
    res_ready = 1'b0;
    tag = 1;
    accepts = 0;
    have_snap = 1'b0;
    req_valid = 2'b01;
    for (int c = 0; c < 6; c++) begin
      req_value[W-1:0] = W'(tag) << (tag * 10);
      req_tag[TW-1:0]  = TW'(tag);
      @(negedge clk);
      acc = req_ready[0];
      if (acc) accepts++;
      if (res_valid) begin
        if (!have_snap) begin
          snap = {res_value, res_shift, res_zero, res_src, res_tag};
          have_snap = 1'b1;
        end else begin
          checks++;
          if ({res_value, res_shift, res_zero, res_src, res_tag} !== snap) begin
            failures++;
            $display("FAIL bp_stable c=%0d: res_tag=%0d res_value=%h changed during stall", c, res_tag, res_value);
          end
        end
      end
      cyc();
      if (acc) tag++;
    end
    req_value[W-1:0] = W'(tag) << (tag * 10);
    req_tag[TW-1:0]  = TW'(tag);
    checks++;
    if (accepts != 2) begin failures++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || res_valid !== 1'b1 || res_tag !== 4'd1) begin
      failures++;
      $display("FAIL bp_full: req_ready=%b res_valid=%b res_tag=%0d expected 00 1 1", req_ready, res_valid, res_tag);
    end
    cyc();
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = req_valid[0] & req_ready[0];
      if (res_valid && res_ready) begin
        c_tags.push_back(int'(res_tag));
        c_idx.push_back(c);
      end
      cyc();
      if (acc) begin
        if (tag == 4) req_valid = 2'b00;
        else begin
          tag++;
          req_value[W-1:0] = W'(tag) << (tag * 10);
          req_tag[TW-1:0]  = TW'(tag);
        end
      end
    end
    checks++;
    if (c_tags.size() != 4) begin
      failures++;
      $display("FAIL bp_count: got %0d results expected 4", c_tags.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (c_tags[k] != k + 1 || c_idx[k] != c_idx[0] + k) begin
          failures++;
          $display("FAIL bp_order k=%0d: tag=%0d cycle=%0d expected tag=%0d cycle=%0d", k, c_tags[k], c_idx[k], k + 1, c_idx[0] + k);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int hs;
    res_ready = 1'b0;
    req_valid = 2'b01;
    req_value[W-1:0] = one << 17;
    req_tag[TW-1:0]  = 4'd6;
    for (int c = 0; c < 4; c++) cyc();
    req_valid = 2'b11;
    checks++;
    if (res_valid !== 1'b1 || dut.s1_valid !== 1'b1 || dut.rr_ptr !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: res_valid=%b s1_valid=%b rr_ptr=%0d expected 1 1 1", res_valid, dut.s1_valid, dut.rr_ptr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || dut.rr_ptr !== 1'b0 || req_ready !== 2'b00 || res_tag !== '0) begin
      failures++;
      $display("FAIL rst_mid: res_valid=%b rr_ptr=%0d req_ready=%b res_tag=%0d expected 0 0 00 0", res_valid, dut.rr_ptr, req_ready, res_tag);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    res_ready = 1'b1;
    req_tag[TW-1:0] = 4'ha;
    req_tag[TW +: TW] = 4'hb;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant: req_ready=%b expected 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (res_valid && res_ready) hs++;
      cyc();
    end
    checks++;
    if (hs != 1) begin failures++; $display("FAIL rst_no_stale: got %0d results expected 1", hs); end
  endtask

  task automatic test_back_to_back();
    int tag, c_tags[$], c_idx[$];
    logic acc;
    res_ready = 1'b0;
    req_valid = 2'b10;
    tag = 5;
    req_value[W +: W] = W'(tag) << 40;
    req_tag[TW +: TW] = TW'(tag);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = req_ready[1];
      cyc();
      if (acc && tag < 7) begin
        tag++;
        req_value[W +: W] = W'(tag) << 40;
        req_tag[TW +: TW] = TW'(tag);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || dut.s1_valid !== 1'b1 || req_ready !== 2'b10 || res_tag !== 4'd5) begin
      failures++;
      $display("FAIL b2b_concurrent: res_valid=%b s1_valid=%b req_ready=%b res_tag=%0d expected 1 1 10 5",
               res_valid, dut.s1_valid, req_ready, res_tag);
    end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      acc = req_valid[1] & req_ready[1];
      if (res_valid && res_ready) begin
        c_tags.push_back(int'(res_tag));
        c_idx.push_back(c);
      end
      cyc();
      if (acc) req_valid = 2'b00;
    end
    checks++;
    if (c_tags.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected 3", c_tags.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (c_tags[k] != k + 5 || c_idx[k] != k) begin
          failures++;
          $display("FAIL b2b_order k=%0d: tag=%0d cycle=%0d expected tag=%0d cycle=%0d", k, c_tags[k], c_idx[k], k + 5, k);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_value = '0;
    req_tag   = '0;
    res_ready = 1'b0;
    #2;
    test_reset();
    test_normalize(one << 50, 4'd3, one << 105, 55, 1'b0);
    test_normalize((one << 105) | W'(106'h123456789abcdef), 4'd7, (one << 105) | W'(106'h123456789abcdef), 0, 1'b0);
    test_normalize(one, 4'd9, one << 105, 105, 1'b0);
    test_normalize(W'(106'h3c5), 4'd2, W'(106'h3c5) << 96, 96, 1'b0);
    test_normalize('0, 4'd12, '0, 0, 1'b1);
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL final_drain: %0d results outstanding expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_norm_arbiter.md
# fpu_norm_arbiter

Shared normalization engine for the FPU. It arbitrates among NREQ producers that need leading-one normalization, such as the multiplier's 106-bit product path and the adder's post-subtract path. One leading-one detector and one left shifter serve all producers. Requests pass through a 2-stage pipeline with valid/ready handshakes on both sides, and each result returns the normalized mantissa, the shift amount, a zero flag and the originating requester and tag.

## Interface
Parameters:
- WIDTH, 106, mantissa width in bits.
- WIDTH_LOG, 7, encoder depth; 2^WIDTH_LOG must be ≥ WIDTH.
- NREQ, 2, number of requesters (≥ 2).
- TAG_W, 4, opaque tag width, returned unchanged.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_value  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_tag  in  NREQ*TAG_W  requester i occupies bits [i*TAG_W +: TAG_W].
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_value  out  WIDTH  normalized mantissa, leading one at bit WIDTH-1.
- res_shift  out  WIDTH_LOG+1  left-shift amount applied.
- res_zero  out  1  input was all zeros.
- res_src  out  $clog2(NREQ)  index of the granted requester.
- res_tag  out  TAG_W  tag of the request.

## Operation
- Arbitration is round-robin. The pointer `rr_ptr` resets to 0. The grant goes to the first i with req_valid[i], searching from rr_ptr upward and wrapping at NREQ.
- req_ready[i] = grant[i] & s1_load. req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- A request transfers when req_valid[i] & req_ready[i]. On a transfer, rr_ptr becomes grant index + 1, wrapping at NREQ. If no transfer occurs, rr_ptr holds.
- Stage 1 (S1) registers value, src and tag. The leading-one index `msb` is computed combinationally on the S1 value, zero-extended to 2^WIDTH_LOG bits. S1 also computes zero = ~|value.
- Stage 2 (S2) registers the following:
  - shift = zero ? 0 : (WIDTH-1) - msb, computed at width WIDTH_LOG+1.
  - value << shift, truncated to WIDTH bits.
  - zero, src and tag.
  - S2 drives all res_* outputs directly from registers.
- Stall rules:
  - s2_load = ~s2_valid | res_ready.
  - s1_load = ~s1_valid | s2_load.
  - S1 advances into S2 when s1_valid & s2_load. A register that is not loaded holds its contents.
  - When S1 advances and no new request arrives in the same cycle, s1_valid clears.
- Simultaneous events:
  - A new accept into S1 and an S1→S2 move in the same cycle are both legal. Both happen.
  - A res handshake and an S2 load in the same cycle give back-to-back results.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- While res_valid is high and res_ready is low, all res_* outputs hold stable.

## Timing
- Reset (asynchronous, rst_n=0):
  - s1_valid, s2_valid, res_valid and rr_ptr go to 0.
  - res_value, res_shift, res_zero, res_src and res_tag go to 0.
  - req_ready is 0 during reset.
- Reset mid-operation discards in-flight entries. No result is produced for them.
- Latency: a request accepted in cycle N gives res_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: 1 result per cycle sustained.
- Capacity: 2 entries. With res_ready held low, at most 2 further accepts occur, then req_ready goes all-0 until res_ready rises.
- Critical path is the S1 encoder plus shift subtract. The barrel shift sits between the S1 and S2 registers.

## Structure
- Shared package fpu_pkg holds:
  - the constants FPU_MANT_W=106 and FPU_MANT_LOG=7;
  - a norm_result_t struct {value, shift, zero, src, tag}.
- The sub-module is the existing fpu_pri_encoder, instantiated once with WIDTH and WIDTH_LOG on the S1 value.
  - Only msb[WIDTH_LOG-1:0] is used; bit WIDTH_LOG is ignored.
  - Zero detection is done locally, not through the encoder.
- Arbiter, pipeline registers and shifter all live in fpu_norm_arbiter; there are no other sub-modules.

## Test plan
All scenarios use the default parameters.
1. Basic normalization:
   - Requester 0, value=1<<50, tag=3, res_ready=1 → two cycles later res_value=1<<105, res_shift=55, res_zero=0, res_src=0, res_tag=3.
   - value with bit 105 set → res_shift=0, value unchanged.
   - value=1 → res_shift=105.
2. Zero input: value=0 → res_zero=1, res_shift=0, res_value=0.
3. Fairness: both requesters valid every cycle from reset → grants run 0,1,0,1,…. With only requester 1 valid → it is granted every cycle.
4. Backpressure:
   - Send 4 requests with tags 1–4 while res_ready=0 for 6 cycles → exactly 2 accepts, then req_ready=0.
   - Raise res_ready → tags 1,2,3,4 come out in order, one per cycle, with res_* stable throughout the stall.
5. Reset mid-flight: assert rst_n=0 with both stages full → res_valid=0 and rr_ptr=0 immediately. After release, the first grant goes to requester 0 and no stale result appears.
6. Concurrency: in one cycle a res handshake, an S1→S2 move and a new accept all occur → 3 back-to-back results with no bubble and no loss.
